// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: frame-clear pulse, then the word LSB-first with bit_valid/last.
// Optional one-word holding register for gapless framing: define SERIAL_WORD_FEEDER_DBUF_EN.
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             ser_out,
  output logic             frame_rst,
  output logic             bit_valid,
  output logic             last,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              frame_rst_q, frame_rst_d;
  logic              bit_valid_q, bit_valid_d;
  logic              last_q, last_d;
  logic              accept;

`ifdef SERIAL_WORD_FEEDER_DBUF_EN
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  assign ready = ~hold_full_q;
`else
  assign ready = (state_q == IDLE);
`endif

  // Handshake: a word is taken on any rising edge where load=1, ready=1 and reset=0.
  assign accept = load & ready;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = 1'b0;
    frame_rst_d = 1'b0;
    bit_valid_d = 1'b0;
    last_d      = 1'b0;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d      = din;
          cnt_d       = '0;
          frame_rst_d = 1'b1;
          state_d     = CLR;
        end
      end
      CLR: begin
        ser_out_d   = sreg_q[0];
        sreg_d      = sreg_q >> 1;
        bit_valid_d = 1'b1;
        last_d      = (LAST_IDX == '0);
        cnt_d       = '0;
        state_d     = SHIFT;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
        if (accept) begin
          hold_d      = din;
          hold_full_d = 1'b1;
        end
`endif
      end
      SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
          // Chain the next word straight into its CLR cycle, no idle gap.
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            frame_rst_d = 1'b1;
            state_d     = CLR;
          end else if (accept) begin
            sreg_d      = din;
            cnt_d       = '0;
            frame_rst_d = 1'b1;
            state_d     = CLR;
          end
`endif
        end else begin
          ser_out_d   = sreg_q[0];
          sreg_d      = sreg_q >> 1;
          bit_valid_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          last_d      = ((cnt_q + CW'(1)) == LAST_IDX);
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      frame_rst_q <= 1'b0;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      frame_rst_q <= frame_rst_d;
      bit_valid_q <= bit_valid_d;
      last_q      <= last_d;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign ser_out   = ser_out_q;
  assign frame_rst = frame_rst_q;
  assign bit_valid = bit_valid_q;
  assign last      = last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed scenarios plus random loads/resets against a
// frame-schedule model (each accepted word owns a frame_rst cycle f and data cycles f+1..f+WIDTH).
module tb_serial_word_feeder;

  localparam int W = 8;
`ifdef SERIAL_WORD_FEEDER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] din;
  logic         ready, ser_out, frame_rst, bit_valid, last;
  logic [1:0]   dbg_state;

  serial_word_feeder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din),
    .ready(ready), .ser_out(ser_out), .frame_rst(frame_rst),
    .bit_valid(bit_valid), .last(last), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int           rec_a[$];
  int           rec_f[$];
  logic [W-1:0] rec_w[$];
  logic [W-1:0] exp_q[$];
  int           last_f = -1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called just after a falling edge: check this cycle's outputs, then drive this cycle's inputs.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] dn);
    logic         e_fr, e_bv, e_so, e_last, e_rdy;
    logic [W-1:0] word;
    int           idx;
    e_fr = 0; e_bv = 0; e_so = 0; e_last = 0; e_rdy = 1;
    for (int i = 0; i < rec_f.size(); i++) begin
      if (rec_f[i] == cyc) e_fr = 1;
      if (cyc >= rec_f[i] + 1 && cyc <= rec_f[i] + W) begin
        word   = rec_w[i];
        idx    = cyc - rec_f[i] - 1;
        e_bv   = 1;
        e_so   = word[idx];
        e_last = (idx == W - 1);
      end
      if (DBUF) begin
        if (rec_a[i] < cyc && cyc < rec_f[i]) e_rdy = 0;
      end else begin
        if (rec_a[i] < cyc && cyc <= rec_f[i] + W) e_rdy = 0;
      end
    end
    check("ready", {31'd0, ready}, {31'd0, e_rdy});
    check("frame_rst", {31'd0, frame_rst}, {31'd0, e_fr});
    check("bit_valid", {31'd0, bit_valid}, {31'd0, e_bv});
    check("ser_out", {31'd0, ser_out}, {31'd0, e_so});
    check("last", {31'd0, last}, {31'd0, e_last});
    if (last === 1'b1 && e_last && exp_q.size() > 0) begin
      word = exp_q.pop_front();
      check("last_word_seen", {31'd0, last}, {31'd0, 1'b1});
    end
    reset = rst;
    load  = ld;
    din   = dn;
    if (rst) begin
      rec_a.delete(); rec_f.delete(); rec_w.delete(); exp_q.delete();
      last_f = -1000;
    end else if (ld && e_rdy) begin
      int f;
      f = cyc + 1;
      if (DBUF && last_f + W >= cyc) f = last_f + W + 1;
      rec_a.push_back(cyc);
      rec_f.push_back(f);
      rec_w.push_back(dn);
      exp_q.push_back(dn);
      last_f = f;
    end
    while (rec_f.size() > 0 && rec_f[0] + W < cyc - 2) begin
      void'(rec_a.pop_front());
      void'(rec_f.pop_front());
      void'(rec_w.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Collects the serial stream of a directed frame and compares the reassembled word.
  task automatic frame_word(input logic [W-1:0] w, input string tag);
    logic [W-1:0] got;
    int           n;
    got = '0;
    n   = 0;
    step(1'b0, 1'b1, w);
    for (int i = 0; i < W + 4; i++) begin
      if (bit_valid === 1'b1 && n < W) begin
        got[n] = ser_out;
        n++;
      end
      step(1'b0, 1'b0, '0);
    end
    check({tag, "_word"}, {{(32-W){1'b0}}, got}, {{(32-W){1'b0}}, w});
    check({tag, "_complement"}, {{(32-W){1'b0}}, W'(~got + 1'b1)}, {{(32-W){1'b0}}, W'(-w)});
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    check("reset_dbg_state", {30'd0, dbg_state}, 32'd0);

    frame_word(8'h0C, "w0C");
    frame_word(8'h00, "w00");

    // Second load at relative cycle 4 lands mid-frame.
    step(1'b0, 1'b1, 8'hA5);
    idle(3);
    step(1'b0, 1'b1, 8'hFF);
    idle(W + 12);

    // Reset mid-frame aborts the word; no last for it.
    step(1'b0, 1'b1, 8'h3C);
    idle(4);
    step(1'b1, 1'b0, '0);
    idle(W + 4);

    // Early second load exercises the holding register when present.
    step(1'b0, 1'b1, 8'h01);
    idle(2);
    step(1'b0, 1'b1, 8'h80);
    idle(2 * W + 6);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, W'($urandom));
    end
    idle(W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial front end for the bit-serial two's complementer. Accepts a parallel word through a ready/load handshake and streams it LSB-first on a single-bit output, one bit per clock. Before each word it emits a one-cycle frame-clear pulse. That pulse drives the complementer's reset input, so every word is complemented independently. It also supplies bit-valid and last-bit qualifiers for the downstream collector.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high reset
- load  input  1  word-load request; sampled only when ready=1 and reset=0
- din  input  WIDTH  parallel word, captured on an accepted load
- ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial data bit, LSB first; wired to the complementer's inp
- frame_rst  output  1  one-cycle frame-clear pulse; wired to the complementer's reset
- bit_valid  output  1  ser_out carries a valid data bit this cycle
- last  output  1  the current bit is bit WIDTH-1 of the word

## Operation
- All outputs are registered. The only exception is ready, which is decoded from registered state.
- FSM states and transitions:
  - IDLE: ready=1. When load=1, capture din into the shift register, clear the bit counter, go to CLR.
  - CLR: frame_rst=1, bit_valid=0, ser_out=0. Lasts exactly 1 cycle, then go to SHIFT.
  - SHIFT: ser_out=sreg[0], bit_valid=1. Shift right by 1 each cycle and increment the counter.
    - When the counter reaches WIDTH-1, assert last on that bit.
    - The next state is IDLE, or CLR if a word is held (see Configuration).
- Bit counter width is $clog2(WIDTH) bits. It never wraps within a frame and is cleared on entry to CLR.
- A load while ready=0 is ignored. It has no effect on state, data or outputs.
- The shift register zero-fills from the MSB. Bits beyond WIDTH are never emitted.
- A word of all zeros still produces the full frame: WIDTH valid bits, with last on the final bit.

## Timing
- Reset values: ready=1; ser_out, frame_rst, bit_valid and last all 0; state IDLE; counter 0; holding register empty.
- A reset asserted mid-frame aborts the frame. All outputs take their reset values the cycle after the reset edge. No last pulse is generated for the aborted word.
- Frame timing, with load accepted at edge T0:
  - Cycle after T0: frame_rst=1.
  - Next WIDTH cycles: bit_valid=1, and the i-th of these cycles carries ser_out=din[i].
  - last=1 in the cycle carrying din[WIDTH-1].
- Latency from load acceptance to the first data bit is 2 cycles. A frame occupies WIDTH+1 cycles.
- Without the buffer, ready=0 from the cycle after acceptance through the last-bit cycle. ready=1 again in the following cycle. Maximum throughput is one word per WIDTH+2 cycles.
- frame_rst and bit_valid are never high in the same cycle. last implies bit_valid.

## Configuration
- SERIAL_WORD_FEEDER_DBUF_EN, defined: adds a one-word holding register and full flag.
  - ready = ~hold_full in all states.
  - A load during CLR or SHIFT fills the holding register.
  - On the last-bit cycle with hold_full=1: move the held word into the shift register, clear hold_full, and go directly to CLR.
  - The gap between consecutive frames is exactly the single CLR cycle, giving one word per WIDTH+1 cycles.
  - A load in IDLE with the holding register empty goes straight to the shift register, as without the macro.
- SERIAL_WORD_FEEDER_DBUF_EN, undefined: no holding register. ready=1 only in IDLE, and behaviour is as in Timing.

## Test plan
- WIDTH=8, load din=8'h0C at cycle 0:
  - frame_rst=1 at cycle 1.
  - ser_out = 0,0,1,1,0,0,0,0 over cycles 2-9, with last=1 at cycle 9 and ready=1 at cycle 10.
  - Downstream complementer output reassembles to 8'hF4.
- Load 8'hA5, then pulse load with din=8'hFF at cycle 4 (macro off): the second load is ignored and the serial stream is exactly 8'hA5.
- Macro on: load 8'h01 at cycle 0 and 8'h80 at cycle 3.
  - First frame's last bit at cycle 9.
  - frame_rst at cycle 10.
  - Bits of 8'h80 on cycles 11-18, with ser_out=1 only at cycle 18.
- Load 8'h3C, assert reset at cycle 5 for 1 cycle: at cycle 6 all outputs are 0 except ready=1, and last is never asserted for that word.
- Load 8'h00: 8 bit_valid cycles with ser_out=0 and last at the 8th; downstream result is 8'h00.
- WIDTH=2, loads of 2'b11 back-to-back: frame_rst, bit 1, bit 1 with last; next frame_rst is at cycle 4 with macro off and cycle 3 with macro on.
